// File: rtl/ioctl_loader_pkg.sv
// Shared types for the ioctl ROM loader: FSM states, FIFO entry layout and
// the default graphics-region base address.
package ioctl_loader_pkg;

  typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_ISSUE, ST_WAIT} ld_state_e;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } fifo_ent_t;

  localparam logic [24:0] GFX_BASE_DEF = 25'h10000;

endpackage

// File: rtl/loader_fifo.sv
// Small synchronous FIFO of {addr,data} bytes; a push on a full FIFO is
// still taken when a pop happens in the same cycle.
module loader_fifo
  import ioctl_loader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  fifo_ent_t din_i,
  input  logic      pop_i,
  output fifo_ent_t dout_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fifo_ent_t       mem_q [DEPTH];
  logic [AW-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rp_q];

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (do_push) wp_d = wp_q + AW'(1);
    if (do_pop)  rp_d = rp_q + AW'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: nothing is read until the count says so.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end

endmodule

// File: rtl/ioctl_rom_loader.sv
// Turns the data_io byte stream into byte-masked 16-bit SDRAM writes on two
// toggle-handshake ports and releases the core once the image has drained.
module ioctl_rom_loader
  import ioctl_loader_pkg::*;
#(
  parameter logic [24:0] GFX_BASE   = GFX_BASE_DEF,
  parameter logic [7:0]  ROM_INDEX  = 8'd0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_downl,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        reset_req,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port1_we,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        port2_we,
  output logic        rom_loaded,
  output logic        core_reset_n,
  output logic        overflow
);

  ld_state_e   state_q, state_d;
  logic        wr_q;
  logic        cap_vld_q, cap_vld_d;
  fifo_ent_t   cap_q, cap_d;
  fifo_ent_t   ent_q, ent_d;
  fifo_ent_t   fifo_dout;
  logic        fifo_full, fifo_empty, pop;
  logic        p1_req_q, p1_req_d, p2_req_q, p2_req_d;
  logic [22:0] p1_a_q, p1_a_d, p2_a_q, p2_a_d;
  logic [1:0]  p1_ds_q, p1_ds_d, p2_ds_q, p2_ds_d;
  logic [15:0] p1_d_q, p1_d_d, p2_d_q, p2_d_d;
  logic        p2_iss_q, p2_iss_d;
  logic        seen_q, seen_d, loaded_q, loaded_d, crst_q, crst_d, ovf_q, ovf_d;
  logic        idx_ok, busy;
  logic [23:0] gfx_off;

  assign idx_ok    = (ioctl_index == ROM_INDEX);
  assign cap_vld_d = ioctl_wr & ~wr_q & ioctl_downl & idx_ok;
  assign cap_d     = cap_vld_d ? '{addr: ioctl_addr, data: ioctl_dout} : cap_q;
  // Bit 24 of the difference never reaches an SDRAM word address.
  assign gfx_off   = ent_q.addr[23:0] - GFX_BASE[23:0];
  assign busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

  loader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_sys),
    .rst_ni  (reset),
    .push_i  (cap_vld_q),
    .din_i   (cap_q),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    ent_d    = ent_q;
    p1_req_d = p1_req_q;
    p1_a_d   = p1_a_q;
    p1_ds_d  = p1_ds_q;
    p1_d_d   = p1_d_q;
    p2_req_d = p2_req_q;
    p2_a_d   = p2_a_q;
    p2_ds_d  = p2_ds_q;
    p2_d_d   = p2_d_q;
    p2_iss_d = p2_iss_q;
    case (state_q)
      ST_SYNC: begin
        // Adopt the controller's ack phase so no request looks pending.
        p1_req_d = port1_ack;
        p2_req_d = port2_ack;
        state_d  = ST_IDLE;
      end
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          ent_d   = fifo_dout;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        p1_a_d   = ent_q.addr[23:1];
        p1_ds_d  = {ent_q.addr[0], ~ent_q.addr[0]};
        p1_d_d   = {ent_q.data, ent_q.data};
        p1_req_d = ~p1_req_q;
        p2_iss_d = (ent_q.addr >= GFX_BASE);
        if (ent_q.addr >= GFX_BASE) begin
          p2_a_d   = gfx_off[23:1];
          p2_ds_d  = {gfx_off[0], ~gfx_off[0]};
          p2_d_d   = {ent_q.data, ent_q.data};
          p2_req_d = ~p2_req_q;
        end
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if ((port1_ack == p1_req_q) && (!p2_iss_q || (port2_ack == p2_req_q)))
          state_d = ST_IDLE;
      end
      default: state_d = ST_SYNC;
    endcase
  end

  assign seen_d   = seen_q | (ioctl_downl & idx_ok);
  assign loaded_d = loaded_q | (~ioctl_downl & seen_q & fifo_empty & ~cap_vld_q &
                                (state_q == ST_IDLE));
  assign crst_d   = loaded_q & ~reset_req & ~ioctl_downl;
  assign ovf_d    = ovf_q | (cap_vld_q & fifo_full & ~pop);

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_SYNC;
      wr_q      <= 1'b0;
      cap_vld_q <= 1'b0;
      cap_q     <= '0;
      ent_q     <= '0;
      p1_req_q  <= 1'b0;
      p1_a_q    <= '0;
      p1_ds_q   <= '0;
      p1_d_q    <= '0;
      p2_req_q  <= 1'b0;
      p2_a_q    <= '0;
      p2_ds_q   <= '0;
      p2_d_q    <= '0;
      p2_iss_q  <= 1'b0;
      seen_q    <= 1'b0;
      loaded_q  <= 1'b0;
      crst_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= ioctl_wr;
      cap_vld_q <= cap_vld_d;
      cap_q     <= cap_d;
      ent_q     <= ent_d;
      p1_req_q  <= p1_req_d;
      p1_a_q    <= p1_a_d;
      p1_ds_q   <= p1_ds_d;
      p1_d_q    <= p1_d_d;
      p2_req_q  <= p2_req_d;
      p2_a_q    <= p2_a_d;
      p2_ds_q   <= p2_ds_d;
      p2_d_q    <= p2_d_d;
      p2_iss_q  <= p2_iss_d;
      seen_q    <= seen_d;
      loaded_q  <= loaded_d;
      crst_q    <= crst_d;
      ovf_q     <= ovf_d;
    end
  end

  assign port1_req    = p1_req_q;
  assign port1_a      = p1_a_q;
  assign port1_ds     = p1_ds_q;
  assign port1_d      = p1_d_q;
  assign port1_we     = ioctl_downl | busy | ~fifo_empty;
  assign port2_req    = p2_req_q;
  assign port2_a      = p2_a_q;
  assign port2_ds     = p2_ds_q;
  assign port2_d      = p2_d_q;
  assign port2_we     = ioctl_downl | busy | ~fifo_empty;
  assign rom_loaded   = loaded_q;
  assign core_reset_n = crst_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_ioctl_rom_loader.sv
// Directed bench for ioctl_rom_loader: an SDRAM ack model with per-port
// delay, a log of every request toggle, and hand-computed expectations.
module tb_ioctl_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b0;
  logic        ioctl_downl = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        reset_req = 1'b0;
  logic        port1_req, port2_req;
  logic        port1_ack = 1'b0, port2_ack = 1'b0;
  logic [22:0] port1_a, port2_a;
  logic [1:0]  port1_ds, port2_ds;
  logic [15:0] port1_d, port2_d;
  logic        port1_we, port2_we;
  logic        rom_loaded, core_reset_n, overflow;

  int          nvec = 0, nerr = 0;
  bit          auto_ack = 1'b1;
  int          dly1 = 0, dly2 = 0, cnt1 = 0, cnt2 = 0;
  logic        p1_prev = 1'b0, p2_prev = 1'b0;
  logic [40:0] log1[$], log2[$];
  int          n1;

  ioctl_rom_loader dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_downl(ioctl_downl),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .reset_req(reset_req),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a),
    .port1_ds(port1_ds), .port1_d(port1_d), .port1_we(port1_we),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a),
    .port2_ds(port2_ds), .port2_d(port2_d), .port2_we(port2_we),
    .rom_loaded(rom_loaded), .core_reset_n(core_reset_n), .overflow(overflow)
  );

  always #10 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sample after the edge, log toggles, then run the ack model.
  task automatic tick();
    @(posedge clk_sys); #1;
    if (port1_req !== p1_prev) begin
      log1.push_back({port1_a, port1_ds, port1_d}); p1_prev = port1_req;
    end
    if (port2_req !== p2_prev) begin
      log2.push_back({port2_a, port2_ds, port2_d}); p2_prev = port2_req;
    end
    if (auto_ack) begin
      if (port1_ack !== port1_req) begin
        if (cnt1 >= dly1) begin port1_ack = port1_req; cnt1 = 0; end else cnt1++;
      end
      if (port2_ack !== port2_req) begin
        if (cnt2 >= dly2) begin port2_ack = port2_req; cnt2 = 0; end else cnt2++;
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    tick(); tick();
    ioctl_wr = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    ticks(3);
    chk("rst_req1", port1_req, 0);  chk("rst_req2", port2_req, 0);
    chk("rst_a1", port1_a, 0);      chk("rst_ds1", port1_ds, 0);
    chk("rst_d1", port1_d, 0);      chk("rst_we1", port1_we, 0);
    chk("rst_we2", port2_we, 0);    chk("rst_loaded", rom_loaded, 0);
    chk("rst_crst", core_reset_n, 0); chk("rst_ovf", overflow, 0);
    reset = 1'b1;
    ticks(2);

    // Byte below the graphics region, immediate ack, 3-clock latency
    ioctl_downl = 1'b1; ioctl_index = 8'd0;
    log1.delete(); log2.delete();
    ioctl_addr = 25'h00001; ioctl_dout = 8'h5A; ioctl_wr = 1'b1;
    tick(); tick(); ioctl_wr = 1'b0; tick();
    chk("t1_lat3", port1_req, 0);
    tick();
    chk("t1_req1", port1_req, 1);   chk("t1_a1", port1_a, 23'h0);
    chk("t1_ds1", port1_ds, 2'b10); chk("t1_d1", port1_d, 16'h5A5A);
    chk("t1_we1", port1_we, 1);
    ticks(3);
    chk("t1_nlog1", log1.size(), 1); chk("t1_nlog2", log2.size(), 0);
    chk("t1_req2", port2_req, 0);

    // Byte in the graphics region: both ports, WAIT holds for slow port2 ack
    log1.delete(); log2.delete();
    dly2 = 15;
    send_byte(25'h10004, 8'hC3); tick();
    chk("t2_req1", port1_req, 0);     chk("t2_req2", port2_req, 1);
    chk("t2_a1", port1_a, 23'h8002);  chk("t2_ds1", port1_ds, 2'b01);
    chk("t2_d1", port1_d, 16'hC3C3);  chk("t2_a2", port2_a, 23'h0002);
    chk("t2_ds2", port2_ds, 2'b01);   chk("t2_d2", port2_d, 16'hC3C3);
    chk("t2_we2", port2_we, 1);
    send_byte(25'h00006, 8'h77); ticks(4);
    chk("t2_held", log1.size(), 1);
    ticks(20);
    chk("t2_nlog1", log1.size(), 2);
    if (log1.size() == 2) chk("t2_w1", log1[1], {23'h3, 2'b01, 16'h7777});
    chk("t2_nlog2", log2.size(), 1);
    chk("t2_a2_held", port2_a, 23'h0002);

    // Slow ack: four spaced strobes, then two back-to-back into a full FIFO
    log1.delete(); log2.delete();
    dly1 = 40; dly2 = 0;
    for (int k = 0; k < 4; k++) begin
      send_byte(25'h20 + 25'(k), 8'hA0 + 8'(k)); ticks(5);
    end
    send_byte(25'h24, 8'hA4);
    chk("t3_ovf0", overflow, 0);
    send_byte(25'h25, 8'hA5); tick();
    chk("t3_ovf1", overflow, 1);
    for (int i = 0; i < 600 && !(log1.size() == 5 && port1_ack === port1_req); i++) tick();
    ticks(60);
    chk("t3_nlog1", log1.size(), 5);
    if (log1.size() == 5) begin
      chk("t3_w0", log1[0], {23'h10, 2'b01, 16'hA0A0});
      chk("t3_w1", log1[1], {23'h10, 2'b10, 16'hA1A1});
      chk("t3_w2", log1[2], {23'h11, 2'b01, 16'hA2A2});
      chk("t3_w3", log1[3], {23'h11, 2'b10, 16'hA3A3});
      chk("t3_w4", log1[4], {23'h12, 2'b01, 16'hA4A4});
    end
    chk("t3_nlog2", log2.size(), 0);

    // Download ends with bytes still queued
    log1.delete();
    dly1 = 20;
    send_byte(25'h30, 8'h01); send_byte(25'h31, 8'h02); send_byte(25'h32, 8'h03);
    ioctl_downl = 1'b0;
    tick();
    chk("t4_early", rom_loaded, 0);
    for (int i = 0; i < 400 && rom_loaded !== 1'b1; i++) tick();
    chk("t4_loaded", rom_loaded, 1);
    chk("t4_nlog1", log1.size(), 3);
    chk("t4_acked", port1_ack, port1_req);
    if (log1.size() == 3) chk("t4_w2", log1[2], {23'h19, 2'b01, 16'h0303});
    chk("t4_crst0", core_reset_n, 0);
    tick();
    chk("t4_crst1", core_reset_n, 1);
    reset_req = 1'b1; tick();
    chk("t4_rreq0", core_reset_n, 0);
    reset_req = 1'b0; tick();
    chk("t4_rreq1", core_reset_n, 1);
    ioctl_downl = 1'b1; tick();
    chk("t4_redl_crst", core_reset_n, 0); chk("t4_redl_loaded", rom_loaded, 1);
    ioctl_downl = 1'b0; tick();
    chk("t4_redl_crst1", core_reset_n, 1);

    // Foreign index ignored
    ioctl_downl = 1'b1; ioctl_index = 8'd1;
    n1 = log1.size();
    send_byte(25'h40, 8'h55); ticks(8);
    chk("t5_nlog1", log1.size(), n1); chk("t5_req2", port2_req, p2_prev);
    ioctl_downl = 1'b0; ioctl_index = 8'd0; tick();
    chk("t5_empty", port1_we, 0);

    // Reset while waiting on an ack, then toggle resync
    auto_ack = 1'b0;
    ioctl_downl = 1'b1;
    send_byte(25'h50, 8'h99); tick();
    ioctl_downl = 1'b0;
    port1_ack = 1'b1;
    reset = 1'b0; ticks(2);
    chk("t6_rst_req1", port1_req, 0);
    reset = 1'b1; tick();
    chk("t6_sync_req1", port1_req, 1);
    chk("t6_sync_req2", port2_req, port2_ack);
    n1 = log1.size();
    ticks(10);
    chk("t6_noissue", log1.size(), n1); chk("t6_req1", port1_req, 1);
    chk("t6_we1", port1_we, 0);       chk("t6_we2", port2_we, 0);
    chk("t6_loaded", rom_loaded, 0);  chk("t6_ovf", overflow, 0);
    chk("t6_crst", core_reset_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
